// File: rtl/wb_io_mailbox.sv
// rtl/wb_io_mailbox.sv - Wishbone slave driving user pads plus a mailbox FIFO with sticky flags and level irq
module wb_io_mailbox #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          IO_PADS    = 38,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rstn_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  output logic               irq
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   io_out_q, io_out_d;
  logic [31:0]   io_oe_q, io_oe_d;
  logic [3:0]    thr_q, thr_d;
  logic          ien_q, ien_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          irq_q, irq_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];

  logic        req, wr, rd, empty, full, push, pop, flush;
  logic [2:0]  off;
  logic [31:0] status, ctrl;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    wr     = req & wbs_we_i;
    rd     = req & ~wbs_we_i;
    off    = wbs_adr_i[4:2];
    empty  = (count_q == 4'd0);
    full   = (count_q == DEPTH_C);
    push   = wr && (off == 3'd2);
    pop    = rd && (off == 3'd2);
    flush  = wr && (off == 3'd4) && wbs_sel_i[0] && wbs_dat_i[0];
    status = {24'd0, udf_q, ovf_q, full, empty, count_q};
    ctrl   = {23'd0, ien_q, thr_q, 4'd0};

    ack_d    = req;
    dat_d    = dat_q;
    io_out_d = io_out_q;
    io_oe_d  = io_oe_q;
    thr_d    = thr_q;
    ien_d    = ien_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    if (rd) begin
      case (off)
        3'd0:    dat_d = io_out_q;
        3'd1:    dat_d = io_oe_q;
        3'd2:    dat_d = empty ? 32'd0 : mem_q[rd_ptr_q];
        3'd3:    dat_d = status;
        3'd4:    dat_d = ctrl;
        default: dat_d = 32'd0;
      endcase
    end

    if (wr) begin
      case (off)
        3'd0: io_out_d = merge_bytes(io_out_q, wbs_dat_i, wbs_sel_i);
        3'd1: io_oe_d  = merge_bytes(io_oe_q, wbs_dat_i, wbs_sel_i);
        3'd3: begin
          if (wbs_dat_i[6]) ovf_d = 1'b0;
          if (wbs_dat_i[7]) udf_d = 1'b0;
        end
        3'd4: begin
          if (wbs_sel_i[0]) thr_d = wbs_dat_i[7:4];
          if (wbs_sel_i[1]) ien_d = wbs_dat_i[8];
        end
        default: ;
      endcase
    end

    // flush only resets occupancy; sticky flags survive it
    if (flush) begin
      count_d  = 4'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_d[wr_ptr_q] = wbs_dat_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        count_d         = count_q + 4'd1;
      end
    end else if (pop) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - 4'd1;
      end
    end

    irq_d = ien_q & (count_q >= thr_q) & (thr_q != 4'd0);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      io_out_q <= 32'd0;
      io_oe_q  <= 32'd0;
      thr_q    <= 4'd0;
      ien_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
      count_q  <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      thr_q    <= thr_d;
      ien_q    <= ien_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;
  assign io_out    = {{(IO_PADS-32){1'b0}}, io_out_q};
  assign io_oeb    = {{(IO_PADS-32){1'b1}}, ~io_oe_q};

endmodule

// File: tb/tb_wb_io_mailbox.sv
// tb/tb_wb_io_mailbox.sv - directed bench for wb_io_mailbox
module tb_wb_io_mailbox;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_IO = BASE + 32'h00;
  localparam logic [31:0] A_OE = BASE + 32'h04;
  localparam logic [31:0] A_FD = BASE + 32'h08;
  localparam logic [31:0] A_ST = BASE + 32'h0C;
  localparam logic [31:0] A_CT = BASE + 32'h10;
  localparam logic [31:0] A_RS = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_out, io_oeb;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  wb_io_mailbox dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] r, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    lat = 0;
    while (ack !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_ack"}, ack, 1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb_xfer(tag, a, 1'b1, 4'hF, d, r, l);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, output logic [31:0] r);
    int l;
    wb_xfer(tag, a, 1'b0, 4'hF, 32'd0, r, l);
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int acks;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_io_out", io_out, 0);
    check("rst_io_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    check("rst_irq", irq, 0);

    // pad output register, full word then single byte lane
    wb_xfer("io_wr", A_IO, 1'b1, 4'hF, 32'hAB60_0000, r, lat);
    check("io_lat", lat, 1);
    check("io_out_hi", io_out[31:16], 16'hAB60);
    wb_xfer("io_wr2", A_IO, 1'b1, 4'b0100, 32'h0061_0000, r, lat);
    check("io_out_sel", io_out[31:16], 16'hAB61);
    check("io_out_top", io_out[37:32], 6'h00);

    wr("oe_wr", A_OE, 32'hFFFF_0000);
    check("oeb_hi", io_oeb[31:16], 16'h0000);
    check("oeb_lo", io_oeb[15:0], 16'hFFFF);
    check("oeb_top", io_oeb[37:32], 6'h3F);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) wr("push", A_FD, i);
    rd("st_rd", A_ST, r);
    check("st_full", r, 32'h28);
    wr("push9", A_FD, 32'h9);
    rd("st_rd", A_ST, r);
    check("st_ovf", r, 32'h68);
    for (int i = 1; i <= 8; i++) begin
      rd("pop", A_FD, r);
      check("pop_data", r, i);
    end
    rd("st_rd", A_ST, r);
    check("st_drained", r, 32'h50);

    rd("pop_empty", A_FD, r);
    check("pop_empty_data", r, 0);
    rd("st_rd", A_ST, r);
    check("st_udf", r, 32'hD0);
    wr("st_clr", A_ST, 32'hC0);
    rd("st_rd", A_ST, r);
    check("st_cleared", r, 32'h10);

    // reserved offset
    wr("rsv_wr", A_RS, 32'hDEAD_BEEF);
    rd("rsv_rd", A_RS, r);
    check("rsv_zero", r, 0);

    // threshold interrupt
    wr("ctrl_wr", A_CT, 32'h130);
    for (int i = 0; i < 3; i++) wr("push", A_FD, 32'hA0 + i);
    check("irq_not_yet", irq, 0);
    @(posedge clk); #1;
    check("irq_rise", irq, 1);
    rd("pop", A_FD, r);
    check("irq_pop_data", r, 32'hA0);
    @(posedge clk); #1;
    check("irq_fall", irq, 0);
    wr("flush", A_CT, 32'h131);
    rd("st_rd", A_ST, r);
    check("st_flushed", r, 32'h10);
    rd("ctrl_rd", A_CT, r);
    check("ctrl_rd", r, 32'h130);

    // reset in the middle of a write
    wr("ctrl_wr", A_CT, 32'h110);
    wr("push", A_FD, 32'h55);
    @(posedge clk); #1;
    check("irq_pre_rst", irq, 1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = A_IO; wdat = 32'h1234_5678;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_io_out", io_out, 0);
    check("mid_rst_io_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_dat", rdat, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rd("st_rd", A_ST, r);
    check("post_rst_st", r, 32'h10);
    rd("ctrl_rd", A_CT, r);
    check("post_rst_ctrl", r, 0);
    check("post_rst_io_out", io_out, 0);

    // out-of-range block address
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0100;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    check("oor_no_ack", acks, 0);
    cyc = 1'b0; stb = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
